inst_fetch_queue: RTL and testbench

- Consumer end of the fetch-address path. Takes the PC stream produced by the PC generator (`pc` plus a valid bit) and issues requests to instruction memory over a split address/data handshake.
- Pairs each returned instruction word with its PC and buffers the pairs in an in-order queue for decode.
- Handles pipeline flush (branch/exception redirect) by discarding queued entries and in-flight responses.

---
 rtl/inst_fetch_queue_pkg.sv | 24 ++
 rtl/inst_fetch_queue_if.sv | 33 +++
 rtl/inst_fetch_queue_chk.sv | 22 ++
 rtl/inst_fetch_queue_sync_fifo.sv | 80 ++++++++
 rtl/inst_fetch_queue.sv | 144 ++++++++++++++
 tb/tb_inst_fetch_queue.sv | 246 ++++++++++++++++++++++++
 6 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Holds the queue entry layout, the architectural reset PC and the
// pointer/count widths derived from the default queue depth.
package ifq_pkg;

   localparam int IFQ_DEPTH  = 4;
   localparam int IFQ_PTR_W  = $clog2(IFQ_DEPTH);
   localparam int IFQ_CNT_W  = IFQ_PTR_W + 1;
   localparam int IFQ_ADDR_W = 32;
   localparam int IFQ_INST_W = 32;

   localparam logic [IFQ_ADDR_W-1:0] PC_RESET_VEC = 32'h1c00_0000;

   typedef struct packed {
      logic [IFQ_ADDR_W-1:0] pc;
      logic [IFQ_INST_W-1:0] inst;
   } ifq_entry_t;

   // Counts need one extra bit over the pointers so that "full" is representable.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-path bundle: PC generator handshake, split address/data memory
// handshake, and the decode-side queue head.
// slave  = the fetch queue itself, master = its environment.
interface inst_fetch_queue_if
   import ifq_pkg::*;
#(
   parameter int ADDR_W = IFQ_ADDR_W,
   parameter int INST_W = IFQ_INST_W
);
   logic              pc_valid;
   logic [ADDR_W-1:0] pc;
   logic              pc_ready;
   logic              flush;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_addr_ok;
   logic              imem_data_ok;
   logic [INST_W-1:0] imem_rdata;
   logic              ifq_valid;
   logic [ADDR_W-1:0] ifq_pc;
   logic [INST_W-1:0] ifq_inst;
   logic              ifq_ready;

   modport slave (
      input  pc_valid, pc, flush, imem_addr_ok, imem_data_ok, imem_rdata, ifq_ready,
      output pc_ready, imem_req, imem_addr, ifq_valid, ifq_pc, ifq_inst
   );

   modport master (
      output pc_valid, pc, flush, imem_addr_ok, imem_data_ok, imem_rdata, ifq_ready,
      input  pc_ready, imem_req, imem_addr, ifq_valid, ifq_pc, ifq_inst
   );
endinterface

// File: rtl/inst_fetch_queue_chk.sv
// Protocol and invariant checks for the fetch queue.
module inst_fetch_queue_chk (
   input logic clk,
   input logic rstn,
   input logic data_ok_i,
   input logic pend_empty_i,
   input logic accept_i,
   input logic pend_full_i,
   input logic q_push_i,
   input logic q_full_i
);
   // Memory must not return data with nothing outstanding.
   a_resp_without_req: assert property (@(posedge clk) disable iff (!rstn)
      !(data_ok_i && pend_empty_i));

   // Credit accounting keeps both FIFOs from overflowing.
   a_pend_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
      !(accept_i && pend_full_i));

   a_queue_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
      !(q_push_i && q_full_i));
endmodule

// File: rtl/inst_fetch_queue_sync_fifo.sv
// Generic synchronous FIFO with occupancy count and synchronous clear.
// Pointers wrap naturally, so DEPTH must be a power of two.
// Push when full and pop when empty are ignored; clear wins over both.
module sync_fifo
   import ifq_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);
   localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok_s, pop_ok_s;

   assign full_o    = (count_q == CNT_FULL);
   assign empty_o   = (count_q == {CNT_W{1'b0}});
   assign count_o   = count_q;
   assign rdata_o   = mem_q[rd_ptr_q];
   assign push_ok_s = push_i & ~full_o & ~clear_i;
   assign pop_ok_s  = pop_i & ~empty_o & ~clear_i;

   // Next pointers and occupancy from this cycle's push/pop/clear.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         wr_ptr_d = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
         rd_ptr_d = pop_ok_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are only observed behind a valid count.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues PCs to instruction memory under a
// credit limit, pairs in-order responses with their PCs, and buffers the
// pairs for decode. A flush empties the queue and marks all outstanding
// responses for discard; new requests wait until they have drained.
// The pending-PC FIFO occupancy doubles as the in-flight request count.
// Optional macro IFQ_BYPASS_EN: a response arriving at an empty queue is
// presented to decode in the same cycle.
module inst_fetch_queue
   import ifq_pkg::*;
#(
   parameter int DEPTH  = IFQ_DEPTH,
   parameter int ADDR_W = IFQ_ADDR_W,
   parameter int INST_W = IFQ_INST_W
) (
   input logic                clk,
   input logic                rstn,
   inst_fetch_queue_if.slave  bus
);
   localparam int CNT_W = cnt_w(DEPTH);
   localparam int ENT_W = ADDR_W + INST_W;
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W:0]   DEPTH_CNT = (CNT_W+1)'(DEPTH);

   logic              pend_full_s, pend_empty_s;
   logic [CNT_W-1:0]  pend_count_s;
   logic [ADDR_W-1:0] pend_pc_s;
   logic              q_full_s, q_empty_s;
   logic [CNT_W-1:0]  q_count_s;
   logic [ENT_W-1:0]  q_wdata_s, q_rdata_s;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic [CNT_W:0]    used_s;
   logic              credit_ok_s, req_s, accept_s;
   logic              resp_s, resp_keep_s, q_push_s, q_pop_s;
   logic              out_valid_s;
   logic [ENT_W-1:0]  out_ent_s;
   logic [ADDR_W-1:0] out_pc_s;
   logic [INST_W-1:0] out_inst_s;

   // Credit: queued entries plus outstanding requests may not exceed DEPTH.
   assign used_s      = {1'b0, q_count_s} + {1'b0, pend_count_s};
   assign credit_ok_s = (used_s < DEPTH_CNT);
   assign req_s       = rstn & bus.pc_valid & ~bus.flush & credit_ok_s
                        & (drop_cnt_q == CNT_ZERO) & ~pend_full_s;
   assign accept_s    = req_s & bus.imem_addr_ok;

   // A response with nothing outstanding is ignored.
   assign resp_s      = bus.imem_data_ok & ~pend_empty_s;
   assign resp_keep_s = resp_s & ~bus.flush & (drop_cnt_q == CNT_ZERO);
   assign q_wdata_s   = {pend_pc_s, bus.imem_rdata};
   assign q_pop_s     = ~q_empty_s & bus.ifq_ready;

`ifdef IFQ_BYPASS_EN
   logic bypass_s;
   assign bypass_s    = resp_keep_s & q_empty_s;
   assign q_push_s    = resp_keep_s & ~(bypass_s & bus.ifq_ready);
   assign out_valid_s = ~q_empty_s | bypass_s;
   assign out_ent_s   = bypass_s ? q_wdata_s : q_rdata_s;
`else
   assign q_push_s    = resp_keep_s;
   assign out_valid_s = ~q_empty_s;
   assign out_ent_s   = q_rdata_s;
`endif

   assign bus.imem_req  = req_s;
   assign bus.imem_addr = bus.pc;
   assign bus.pc_ready  = accept_s;
   assign bus.ifq_valid = out_valid_s;
   assign bus.ifq_pc    = out_pc_s;
   assign bus.ifq_inst  = out_inst_s;

   // Head fields are forced to zero when nothing valid is presented.
   always_comb begin
      out_pc_s   = {ADDR_W{1'b0}};
      out_inst_s = {INST_W{1'b0}};
      if (out_valid_s) begin
         out_pc_s   = out_ent_s[ENT_W-1:INST_W];
         out_inst_s = out_ent_s[INST_W-1:0];
      end else begin
         out_pc_s   = {ADDR_W{1'b0}};
         out_inst_s = {INST_W{1'b0}};
      end
   end

   // Drop count: on flush, everything still outstanding after this cycle's
   // response becomes stale; otherwise each stale response retires one.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (bus.flush) begin
         drop_cnt_d = pend_count_s - CNT_W'(resp_s);
      end else if (resp_s && (drop_cnt_q != CNT_ZERO)) begin
         drop_cnt_d = drop_cnt_q - CNT_ONE;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   // Drop count register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         drop_cnt_q <= CNT_ZERO;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_pend_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .clear_i (1'b0),
      .push_i  (accept_s),
      .wdata_i (bus.pc),
      .pop_i   (resp_s),
      .rdata_o (pend_pc_s),
      .full_o  (pend_full_s),
      .empty_o (pend_empty_s),
      .count_o (pend_count_s)
   );

   sync_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_inst_q (
      .clk     (clk),
      .rstn    (rstn),
      .clear_i (bus.flush),
      .push_i  (q_push_s),
      .wdata_i (q_wdata_s),
      .pop_i   (q_pop_s),
      .rdata_o (q_rdata_s),
      .full_o  (q_full_s),
      .empty_o (q_empty_s),
      .count_o (q_count_s)
   );

   inst_fetch_queue_chk u_chk (
      .clk          (clk),
      .rstn         (rstn),
      .data_ok_i    (bus.imem_data_ok),
      .pend_empty_i (pend_empty_s),
      .accept_i     (accept_s),
      .pend_full_i  (pend_full_s),
      .q_push_i     (q_push_s),
      .q_full_i     (q_full_s)
   );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue (default build, DEPTH=4).
// Inputs change 1 time unit after each rising edge; outputs are checked
// shortly afterwards, well before the next edge.
module tb_inst_fetch_queue;
   import ifq_pkg::*;

   logic clk  = 1'b0;
   logic rstn = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   inst_fetch_queue_if #(.ADDR_W(32), .INST_W(32)) bus ();

   inst_fetch_queue #(.DEPTH(4), .ADDR_W(32), .INST_W(32)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic pv, input logic [31:0] p, input logic aok,
                        input logic dok, input logic [31:0] rd, input logic rdy,
                        input logic fl);
      bus.pc_valid     = pv;
      bus.pc           = p;
      bus.imem_addr_ok = aok;
      bus.imem_data_ok = dok;
      bus.imem_rdata   = rd;
      bus.ifq_ready    = rdy;
      bus.flush        = fl;
      #1;
   endtask

   task automatic idle(input logic rdy);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, rdy, 1'b0);
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [31:0] p,
                          input logic [31:0] inst);
      chk1 ({tag, ".ifq_valid"}, bus.ifq_valid, v);
      chk32({tag, ".ifq_pc"},    bus.ifq_pc,    v ? p : 32'h0);
      chk32({tag, ".ifq_inst"},  bus.ifq_inst,  v ? inst : 32'h0);
   endtask

   task automatic chk_req(input string tag, input logic req, input logic rdy);
      chk1({tag, ".imem_req"}, bus.imem_req, req);
      chk1({tag, ".pc_ready"}, bus.pc_ready, rdy);
   endtask

   // Single fetch from an empty queue: one-cycle latency after data_ok.
   task automatic scen_basic(input string tag);
      drive(1'b1, PC_RESET_VEC, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_req({tag, ".issue"}, 1'b1, 1'b1);
      chk32({tag, ".imem_addr"}, bus.imem_addr, PC_RESET_VEC);
      chk_out({tag, ".issue"}, 1'b0, 32'h0, 32'h0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0280_0000, 1'b0, 1'b0);
      chk_out({tag, ".resp"}, 1'b0, 32'h0, 32'h0);
      tick();
      idle(1'b1);
      chk_out({tag, ".head"}, 1'b1, PC_RESET_VEC, 32'h0280_0000);
      tick();
      idle(1'b0);
      chk_out({tag, ".drained"}, 1'b0, 32'h0, 32'h0);
   endtask

   localparam logic [31:0] BASE2 = 32'h1c00_0040;
   localparam logic [31:0] INST2 = 32'h0010_0000;
   localparam logic [31:0] BASE3 = 32'h1c00_0200;
   localparam logic [31:0] INST3 = 32'h0030_0000;
   localparam logic [31:0] BASE4 = 32'h1c00_0300;
   localparam logic [31:0] TGT4  = 32'h1c00_0100;
   localparam logic [31:0] BASE5 = 32'h1c00_0400;
   localparam logic [31:0] TGT5  = 32'h1c00_0500;
   localparam logic [31:0] BASE6 = 32'h1c00_0600;

   initial begin
      logic [31:0] p3;

      // ---------------- reset state ----------------
      #1 rstn = 1'b0;
      drive(1'b1, PC_RESET_VEC, 1'b1, 1'b0, 32'hdead_beef, 1'b1, 1'b0);
      chk_req("rst", 1'b0, 1'b0);
      chk_out("rst", 1'b0, 32'h0, 32'h0);
      tick();
      tick();
      chk_req("rst_held", 1'b0, 1'b0);
      rstn = 1'b1;

      // ---------------- 1: basic fetch ----------------
      scen_basic("s1");

      // ---------------- 2: streaming 8 PCs ----------------
      for (int i = 0; i < 11; i++) begin
         drive(i < 8, 32'(BASE2 + 32'(4 * i)), 1'b1, (i >= 1 && i <= 8),
               32'(INST2 + 32'(i - 1)), 1'b1, 1'b0);
         chk1("s2.pc_ready", bus.pc_ready, i < 8);
         chk_out("s2", (i >= 2 && i <= 9), 32'(BASE2 + 32'(4 * (i - 2))),
                 32'(INST2 + 32'(i - 2)));
         tick();
      end

      // ---------------- 3: credit limit with decode stalled ----------------
      p3 = BASE3;
      for (int c = 0; c < 6; c++) begin
         drive(1'b1, p3, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
         chk_req("s3.fill", c < 4, c < 4);
         if (c < 4) p3 = p3 + 32'h4;
         tick();
      end
      for (int r = 0; r < 4; r++) begin
         drive(1'b1, p3, 1'b1, 1'b1, 32'(INST3 + 32'(r)), 1'b0, 1'b0);
         chk_req("s3.resp", 1'b0, 1'b0);
         chk_out("s3.resp", r > 0, BASE3, INST3);
         tick();
      end
      drive(1'b1, p3, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_req("s3.full", 1'b0, 1'b0);
      chk_out("s3.full", 1'b1, BASE3, INST3);
      tick();
      drive(1'b1, p3, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_req("s3.freed", 1'b1, 1'b1);
      chk_out("s3.freed", 1'b1, BASE3 + 32'h4, INST3 + 32'h1);
      tick();
      drive(1'b1, p3 + 32'h4, 1'b1, 1'b1, INST3 + 32'h4, 1'b0, 1'b0);
      chk_req("s3.refull", 1'b0, 1'b0);
      tick();
      for (int k = 1; k <= 4; k++) begin
         idle(1'b1);
         chk_out("s3.drain", 1'b1, 32'(BASE3 + 32'(4 * k)), 32'(INST3 + 32'(k)));
         tick();
      end
      idle(1'b0);
      chk_out("s3.empty", 1'b0, 32'h0, 32'h0);

      // ---------------- 4: flush with 2 in flight, 1 queued ----------------
      drive(1'b1, BASE4, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      drive(1'b1, BASE4 + 32'h4, 1'b1, 1'b1, 32'h0040_0000, 1'b0, 1'b0);
      tick();
      drive(1'b1, BASE4 + 32'h8, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_out("s4.pre", 1'b1, BASE4, 32'h0040_0000);
      tick();
      drive(1'b1, TGT4, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk_req("s4.flush", 1'b0, 1'b0);
      tick();
      drive(1'b1, TGT4, 1'b1, 1'b1, 32'hbad0_0001, 1'b0, 1'b0);
      chk_req("s4.drop1", 1'b0, 1'b0);
      chk_out("s4.drop1", 1'b0, 32'h0, 32'h0);
      tick();
      drive(1'b1, TGT4, 1'b1, 1'b1, 32'hbad0_0002, 1'b0, 1'b0);
      chk_req("s4.drop2", 1'b0, 1'b0);
      chk_out("s4.drop2", 1'b0, 32'h0, 32'h0);
      tick();
      drive(1'b1, TGT4, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_req("s4.newreq", 1'b1, 1'b1);
      chk32("s4.imem_addr", bus.imem_addr, TGT4);
      chk_out("s4.newreq", 1'b0, 32'h0, 32'h0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0041_0000, 1'b0, 1'b0);
      chk_out("s4.newresp", 1'b0, 32'h0, 32'h0);
      tick();
      idle(1'b1);
      chk_out("s4.head", 1'b1, TGT4, 32'h0041_0000);
      tick();
      idle(1'b0);
      chk_out("s4.empty", 1'b0, 32'h0, 32'h0);

      // ---------------- 5: flush coincident with data_ok and addr_ok ----------------
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 32'(BASE5 + 32'(4 * c)), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
         chk1("s5.fill", bus.pc_ready, 1'b1);
         tick();
      end
      drive(1'b1, BASE5 + 32'hc, 1'b1, 1'b1, 32'hbad0_0010, 1'b0, 1'b1);
      chk_req("s5.flush", 1'b0, 1'b0);
      tick();
      drive(1'b1, TGT5, 1'b1, 1'b1, 32'hbad0_0011, 1'b0, 1'b0);
      chk_req("s5.drop1", 1'b0, 1'b0);
      chk_out("s5.drop1", 1'b0, 32'h0, 32'h0);
      tick();
      drive(1'b1, TGT5, 1'b1, 1'b1, 32'hbad0_0012, 1'b0, 1'b0);
      chk_req("s5.drop2", 1'b0, 1'b0);
      chk_out("s5.drop2", 1'b0, 32'h0, 32'h0);
      tick();
      drive(1'b1, TGT5, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_req("s5.newreq", 1'b1, 1'b1);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0051_0000, 1'b0, 1'b0);
      tick();
      idle(1'b1);
      chk_out("s5.head", 1'b1, TGT5, 32'h0051_0000);
      tick();
      idle(1'b0);
      chk_out("s5.empty", 1'b0, 32'h0, 32'h0);

      // ---------------- 6: reset with requests in flight ----------------
      drive(1'b1, BASE6, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      drive(1'b1, BASE6 + 32'h4, 1'b1, 1'b1, 32'h0060_0000, 1'b0, 1'b0);
      tick();
      drive(1'b1, BASE6 + 32'h8, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      drive(1'b1, BASE6 + 32'hc, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk1("s6.fill", bus.pc_ready, 1'b1);
      tick();
      drive(1'b1, BASE6 + 32'h10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_req("s6.nocredit", 1'b0, 1'b0);
      chk_out("s6.pre", 1'b1, BASE6, 32'h0060_0000);
      rstn = 1'b0;
      #1;
      chk_req("s6.async", 1'b0, 1'b0);
      chk_out("s6.async", 1'b0, 32'h0, 32'h0);
      tick();
      tick();
      chk_req("s6.held", 1'b0, 1'b0);
      rstn = 1'b1;
      scen_basic("s6.after");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
